// File: rtl/pkt_dispatch_n_pkg.sv
// Shared definitions for the packet dispatcher: the default TSMP magic value,
// FSM state encodings, the statistics counter width and a saturating increment.
package pkt_dispatch_n_pkg;

    localparam logic [23:0] DEF_TSMP_MAGIC = 24'h662662;
    localparam int          CNT_W          = 16;

    typedef enum logic [2:0] {
        WAIT_IDLE_S,
        IDLE_S,
        HEAD_S,
        TRANS_S,
        DROP_S
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pkt_hdr_delay.sv
// Header delay line: a DEPTH-stage shift register of {valid,data}.
// Stage 0 holds the newest byte; every stage is exposed so the parser can
// read the buffered header bytes while the packet keeps streaming in.
module pkt_hdr_delay
    import pkt_dispatch_n_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [7:0]           iv_data,
    output logic [DEPTH-1:0][8:0] ov_stage
);

    // Shift one {valid,data} entry per cycle, newest into stage 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_stage <= '0;
        end else begin
            ov_stage <= {ov_stage[DEPTH-2:0], {i_valid, iv_data}};
        end
    end

endmodule

// File: rtl/pkt_dispatch_n.sv
// Packet dispatcher: buffers the first HDR_LEN header bytes, chooses one of
// NUM_PORTS output channels (port 0 = HCP) and forwards the delayed packet to
// that port only. Runt and dropped packets are counted with saturating counters.
// Optional feature macro: PKT_DISPATCH_STAT_EN adds per-port forwarded-packet
// counters on ov_pkt_cnt.
module pkt_dispatch_n
    import pkt_dispatch_n_pkg::*;
#(
    parameter int          NUM_PORTS  = 2,
    parameter int          HDR_LEN    = 6,
    parameter logic [23:0] TSMP_MAGIC = DEF_TSMP_MAGIC
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_data_wr,
    input  logic [7:0]                 iv_data,
    input  logic                       i_dispatch_en,
    output logic [8*NUM_PORTS-1:0]     ov_data,
    output logic [NUM_PORTS-1:0]       ov_data_wr,
    output logic [CNT_W-1:0]           ov_runt_cnt,
    output logic [CNT_W-1:0]           ov_drop_cnt
`ifdef PKT_DISPATCH_STAT_EN
    ,
    output logic [CNT_W*NUM_PORTS-1:0] ov_pkt_cnt
`endif
);

    localparam int              PW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [11:0]     NP_MID       = 12'(NUM_PORTS);
    localparam logic [PW-1:0]   LAST_PORT    = PW'(NUM_PORTS - 1);
    localparam logic [3:0]      LAST_HDR_IDX = 4'(HDR_LEN - 1);

    logic [HDR_LEN-1:0][8:0] stage;
    state_t                  state, state_nxt;
    logic [3:0]              byte_cnt, byte_cnt_nxt;
    logic [PW-1:0]           route, dest;
    logic                    route_load, runt_hit, drop_hit;
    logic                    fwd_en;
    logic [23:0]             hdr_magic;
    logic [11:0]             mid;
    logic                    tail_valid;
    logic [7:0]              tail_data;
    logic [NUM_PORTS-1:0]    port_hit;

    pkt_hdr_delay #(
        .DEPTH (HDR_LEN)
    ) u_hdr_delay (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_data_wr),
        .iv_data  (iv_data),
        .ov_stage (stage)
    );

    // While the last header byte is on the input, bytes 0..4 sit in stages 4..0.
    assign hdr_magic  = {stage[HDR_LEN-2][7:0], stage[HDR_LEN-3][7:0], stage[HDR_LEN-4][7:0]};
    assign mid        = {stage[0][3:0], iv_data};
    assign tail_valid = stage[HDR_LEN-1][8];
    assign tail_data  = stage[HDR_LEN-1][7:0];

    // Destination port from the header: non-TSMP and MID 0 go to HCP, large MIDs clamp to the last port.
    always_comb begin
        route = '0;
        if (hdr_magic == TSMP_MAGIC) begin
            if (mid == 12'd0) begin
                route = '0;
            end else if (mid < NP_MID) begin
                route = mid[PW-1:0];
            end else begin
                route = LAST_PORT;
            end
        end
    end

    // Input-side parser: counts header bytes, flags runts and drops; draining of
    // the delayed tail is handled by fwd_en so a new header can be parsed meanwhile.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        route_load   = 1'b0;
        runt_hit     = 1'b0;
        drop_hit     = 1'b0;
        case (state)
            WAIT_IDLE_S: begin
                if (!i_data_wr) state_nxt = IDLE_S;
            end
            IDLE_S: begin
                if (i_data_wr) begin
                    if (i_dispatch_en) begin
                        state_nxt    = HEAD_S;
                        byte_cnt_nxt = 4'd1;
                    end else begin
                        state_nxt = DROP_S;
                        drop_hit  = 1'b1;
                    end
                end
            end
            HEAD_S: begin
                if (!i_data_wr) begin
                    runt_hit     = 1'b1;
                    state_nxt    = IDLE_S;
                    byte_cnt_nxt = '0;
                end else if (byte_cnt == LAST_HDR_IDX) begin
                    route_load   = 1'b1;
                    state_nxt    = TRANS_S;
                    byte_cnt_nxt = '0;
                end else begin
                    byte_cnt_nxt = byte_cnt + 4'd1;
                end
            end
            TRANS_S: begin
                if (!i_data_wr) state_nxt = IDLE_S;
            end
            DROP_S: begin
                if (!i_data_wr) state_nxt = IDLE_S;
            end
            default: begin
                state_nxt    = WAIT_IDLE_S;
                byte_cnt_nxt = '0;
            end
        endcase
    end

    // Parser state and header byte counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= WAIT_IDLE_S;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Runt and drop counters, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_runt_cnt <= '0;
            ov_drop_cnt <= '0;
        end else begin
            if (runt_hit) ov_runt_cnt <= sat_inc(ov_runt_cnt);
            if (drop_hit) ov_drop_cnt <= sat_inc(ov_drop_cnt);
        end
    end

    // Forward window: opens when the route is latched (byte 0 reaches the tail
    // that same edge) and closes once the tail shows a gap; opening wins so a
    // packet one idle cycle behind the previous one is not lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fwd_en <= 1'b0;
            dest   <= '0;
        end else if (route_load) begin
            fwd_en <= 1'b1;
            dest   <= route;
        end else if (!tail_valid) begin
            fwd_en <= 1'b0;
        end
    end

    // One-hot port select for the byte leaving the delay line this cycle.
    always_comb begin
        port_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_hit[p] = fwd_en && tail_valid && (dest == PW'(p));
        end
    end

    // Registered per-port outputs; unselected ports are held at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_data    <= '0;
            ov_data_wr <= '0;
        end else begin
            ov_data_wr <= port_hit;
            for (int p = 0; p < NUM_PORTS; p++) begin
                ov_data[8*p +: 8] <= port_hit[p] ? tail_data : 8'h00;
            end
        end
    end

`ifdef PKT_DISPATCH_STAT_EN
    logic first_pend;

    // Per-port forwarded-packet counters, bumped as each packet's first byte is output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            first_pend <= 1'b0;
            ov_pkt_cnt <= '0;
        end else begin
            if (route_load) begin
                first_pend <= 1'b1;
            end else if (|port_hit) begin
                first_pend <= 1'b0;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (first_pend && port_hit[p]) begin
                    ov_pkt_cnt[CNT_W*p +: CNT_W] <= sat_inc(ov_pkt_cnt[CNT_W*p +: CNT_W]);
                end
            end
        end
    end
`endif

endmodule
